fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 64-bit in-order pipeline, directly upstream of the IF/ID pipeline register.
//  Owns the PC, issues instruction-bus requests and presents one fetch_data_t per cycle to IF/ID.
//  Absorbs bus latency, downstream stalls and branch/jump redirects.
//  Emits bubbles (is_bubble=1) whenever no valid instruction is available.
// PARAMETERS
//  RESET_PC  64'h8000_0000  PC loaded on reset
//  PC_STEP   4              sequential PC increment, in bytes
// PORTS
//  clk             in   1   single clock; all state updates on posedge
//  reset           in   1   synchronous, active-low (reset==0 resets on next posedge)
//  ireq_valid      out  1   instruction-fetch request valid
//  ireq_addr       out  64  fetch address; stable while ireq_valid && !iresp_data_ok
//  iresp_data_ok   in   1   bus returns data this cycle for the outstanding request
//  iresp_data      in   32  returned instruction word
//  stall_F         in   1   IF/ID cannot advance this cycle (hazard unit)
//  redirect_valid  in   1   branch/jump resolved taken; fetch must restart
//  redirect_pc     in   64  redirect target
//  dataF           out  fetch_data_t  {raw_instr[31:0], pc[63:0], is_bubble}, combinational to IF/ID
// BEHAVIOUR
//  - State regs: state (FETCH/HOLD/FLUSH), pc, req_addr, hold_instr, flush_target.
//  - Reset (reset==0): state=FETCH, pc=req_addr=RESET_PC, hold_instr=0, ireq_valid=0.
//    dataF={0,RESET_PC,1} during reset. First request (addr RESET_PC) issues the cycle after release.
//  - Bus rule: once ireq_valid rises, ireq_valid and ireq_addr hold until iresp_data_ok.
//    At most one request outstanding.
//  - FETCH: ireq_valid=1, ireq_addr=pc.
//    - !data_ok: dataF=bubble.
//    - data_ok && !stall_F: dataF={iresp_data,pc,0}; pc+=PC_STEP; stay FETCH.
//      Throughput is 1 instr/cycle when the bus answers same-cycle.
//    - data_ok && stall_F: dataF={iresp_data,pc,0}; hold_instr=iresp_data; go HOLD.
//  - HOLD: ireq_valid=0; dataF={hold_instr,pc,0}.
//    - !stall_F: pc+=PC_STEP; go FETCH.
//  - FLUSH: ireq_valid=1, ireq_addr=req_addr (old address); dataF=bubble.
//    - data_ok: discard the data; pc=flush_target; go FETCH.
//  - Redirect has priority over stall_F and data_ok. dataF=bubble in the redirect cycle. Target
//    stored with bits [1:0] forced to 0.
//    - FETCH && data_ok: discard; pc=target; stay FETCH.
//    - FETCH && !data_ok: flush_target=target; req_addr=pc; go FLUSH.
//    - HOLD: drop hold_instr; pc=target; go FETCH.
//    - FLUSH: flush_target=target; the latest redirect wins.
//    - FLUSH && data_ok in the same cycle: pc=new target; go FETCH.
//  - pc arithmetic is 64-bit modulo. 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0 without flag.
//  - reset==0 mid-request: state cleared; any late iresp_data_ok with ireq_valid==0 is ignored.
//  - Illegal state encoding: recover to FETCH with pc unchanged.
// STRUCTURE
//  - pipes package: fetch_data_t (existing); add fetch_state_t enum {FETCH,HOLD,FLUSH}.
//  - common package: add RESET_PC constant and the u64/u32 aliases used for pc/instr.
//  - No sub-module. The FSM, PC mux and one-entry hold buffer are inline.
//    The next-PC select is an always_comb block.
// TESTING
//  1. Release reset, bus data_ok each cycle returning 32'h0000_0013 (nop)
//     -> ireq_addr 8000_0000, 8000_0004, 8000_0008...; dataF.is_bubble=0 from the first data_ok.
//  2. Bus latency 3 cycles -> 2 bubble cycles, then {instr, pc=8000_0000};
//     ireq_addr stable for all 3 cycles.
//  3. stall_F=1 for 4 cycles while data returns at pc 8000_0010
//     -> ireq_valid=0; dataF holds {instr, 8000_0010, 0}; after release next ireq_addr=8000_0014.
//  4. Redirect to 8000_0100 while a 3-cycle request to 8000_0020 is pending
//     -> addr stays 8000_0020 until data_ok; data dropped (bubble); next ireq_addr=8000_0100.
//  5. Redirect to 8000_0200 and stall_F=1 in the same cycle data_ok arrives
//     -> bubble; HOLD not entered; next ireq_addr=8000_0200.
//  6. reset=0 for 1 cycle mid-FLUSH
//     -> dataF={0,8000_0000,1}; ireq_valid=0; fetch restarts at 8000_0000 after release.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types for the IF stage: 64/32-bit aliases, reset PC, the IF/ID payload and FSM states.
// Helper functions keep target alignment and bubble construction in one place.
package fetch_stage_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    localparam u64 RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        u32   raw_instr;
        u64   pc;
        logic is_bubble;
    } fetch_data_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    // Instructions are word aligned; the low two bits of a redirect target are discarded.
    function automatic u64 align_target(input u64 target);
        return target & ~64'h3;
    endfunction

    function automatic fetch_data_t make_bubble(input u64 pc);
        fetch_data_t d;
        d.raw_instr = '0;
        d.pc        = pc;
        d.is_bubble = 1'b1;
        return d;
    endfunction

    function automatic fetch_data_t make_instr(input u32 instr, input u64 pc);
        fetch_data_t d;
        d.raw_instr = instr;
        d.pc        = pc;
        d.is_bubble = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-bus request/response bundle between the fetch stage (master) and memory (slave).
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic ireq_valid;
    u64   ireq_addr;
    logic iresp_data_ok;
    u32   iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data
    );

endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, keeps one instruction request on the bus, and hands one
// fetch_data_t per cycle to IF/ID, absorbing bus latency, stalls and redirects.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    fetch_stage_if.master              ibus,
    input  logic                       stall_F,
    input  logic                       redirect_valid,
    input  logic [63:0]                redirect_pc,
    output fetch_stage_pkg::fetch_data_t dataF
);
    import fetch_stage_pkg::*;

    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_HOLD  = HOLD;
    localparam logic [1:0] S_FLUSH = FLUSH;

    localparam u64 STEP = 64'(PC_STEP);

    logic [1:0] state_q, state_d;
    u64         pc_q, pc_d;
    u64         req_addr_q, req_addr_d;
    u32         hold_instr_q, hold_instr_d;
    u64         flush_target_q, flush_target_d;
    u64         target;

    assign target = align_target(redirect_pc);

    // Next-state / next-PC select; redirect outranks both data_ok and stall_F.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_addr_d     = req_addr_q;
        hold_instr_d   = hold_instr_q;
        flush_target_d = flush_target_q;

        case (state_q)
            S_FETCH: begin
                if (redirect_valid) begin
                    if (ibus.iresp_data_ok) begin
                        pc_d = target;
                    end else begin
                        // The request in flight must still complete at its original address.
                        flush_target_d = target;
                        req_addr_d     = pc_q;
                        state_d        = S_FLUSH;
                    end
                end else if (ibus.iresp_data_ok) begin
                    if (!stall_F) begin
                        pc_d = pc_q + STEP;
                    end else begin
                        hold_instr_d = ibus.iresp_data;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = target;
                    state_d = S_FETCH;
                end else if (!stall_F) begin
                    pc_d    = pc_q + STEP;
                    state_d = S_FETCH;
                end
            end
            S_FLUSH: begin
                if (ibus.iresp_data_ok) begin
                    pc_d    = redirect_valid ? target : flush_target_q;
                    state_d = S_FETCH;
                end else if (redirect_valid) begin
                    flush_target_d = target;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Bus request and IF/ID payload; reset forces both quiet regardless of state.
    always_comb begin
        ibus.ireq_valid = 1'b0;
        ibus.ireq_addr  = pc_q;
        dataF           = make_bubble(pc_q);

        if (!reset) begin
            dataF = make_bubble(RESET_PC);
        end else begin
            case (state_q)
                S_FETCH: begin
                    ibus.ireq_valid = 1'b1;
                    if (ibus.iresp_data_ok && !redirect_valid) begin
                        dataF = make_instr(ibus.iresp_data, pc_q);
                    end
                end
                S_HOLD: begin
                    if (!redirect_valid) begin
                        dataF = make_instr(hold_instr_q, pc_q);
                    end
                end
                S_FLUSH: begin
                    ibus.ireq_valid = 1'b1;
                    ibus.ireq_addr  = req_addr_q;
                end
                default: begin
                    ibus.ireq_valid = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_FETCH;
            pc_q           <= RESET_PC;
            req_addr_q     <= RESET_PC;
            hold_instr_q   <= '0;
            flush_target_q <= RESET_PC;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            req_addr_q     <= req_addr_d;
            hold_instr_q   <= hold_instr_d;
            flush_target_q <= flush_target_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each task runs one scenario with hand-computed expectations.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall_F;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    fetch_data_t dataF;

    int total = 0;
    int bad   = 0;

    fetch_stage_if ibus ();

    fetch_stage #(
        .RESET_PC (64'h0000_0000_8000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ibus           (ibus.master),
        .stall_F        (stall_F),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dataF          (dataF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset              = 1'b0;
        ibus.iresp_data_ok = 1'b0;
        ibus.iresp_data    = '0;
        stall_F            = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        reset              = 1'b0;
        ibus.iresp_data_ok = 1'b1;
        ibus.iresp_data    = 32'hDEAD_BEEF;
        stall_F            = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (ibus.ireq_valid !== 1'b0) begin
                bad++; $display("FAIL reset_valid[%0d] got %b want 0", c, ibus.ireq_valid);
            end
            total++;
            if (dataF !== {32'h0, 64'h8000_0000, 1'b1}) begin
                bad++; $display("FAIL reset_dataF[%0d] got %h want %h", c, dataF, {32'h0, 64'h8000_0000, 1'b1});
            end
        end
        ibus.iresp_data_ok = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'h8000_0000}) begin
            bad++; $display("FAIL reset_first_req got %b/%h want 1/80000000", ibus.ireq_valid, ibus.ireq_addr);
        end
        total++;
        if (dataF.is_bubble !== 1'b1) begin
            bad++; $display("FAIL reset_first_bubble got %b want 1", dataF.is_bubble);
        end
    endtask

    task automatic test_sequential;
        logic [63:0] a;
        do_reset();
        ibus.iresp_data_ok = 1'b1;
        ibus.iresp_data    = 32'h0000_0013;
        #1;
        for (int i = 0; i < 5; i++) begin
            a = 64'h8000_0000 + 64'(4 * i);
            total++;
            if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, a}) begin
                bad++; $display("FAIL seq_req[%0d] got %b/%h want 1/%h", i, ibus.ireq_valid, ibus.ireq_addr, a);
            end
            total++;
            if (dataF !== {32'h0000_0013, a, 1'b0}) begin
                bad++; $display("FAIL seq_dataF[%0d] got %h want %h", i, dataF, {32'h0000_0013, a, 1'b0});
            end
            tick();
        end
    endtask

    task automatic test_latency;
        do_reset();
        ibus.iresp_data = 32'h00A0_0093;
        for (int c = 0; c < 3; c++) begin
            ibus.iresp_data_ok = (c == 2);
            #1;
            total++;
            if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'h8000_0000}) begin
                bad++; $display("FAIL lat_req[%0d] got %b/%h want 1/80000000", c, ibus.ireq_valid, ibus.ireq_addr);
            end
            total++;
            if (c < 2 && dataF.is_bubble !== 1'b1) begin
                bad++; $display("FAIL lat_bubble[%0d] got %b want 1", c, dataF.is_bubble);
            end else if (c == 2 && dataF !== {32'h00A0_0093, 64'h8000_0000, 1'b0}) begin
                bad++; $display("FAIL lat_dataF got %h want %h", dataF, {32'h00A0_0093, 64'h8000_0000, 1'b0});
            end
            tick();
        end
        ibus.iresp_data_ok = 1'b0;
        #1;
        total++;
        if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'h8000_0004}) begin
            bad++; $display("FAIL lat_next got %b/%h want 1/80000004", ibus.ireq_valid, ibus.ireq_addr);
        end
    endtask

    task automatic test_stall;
        do_reset();
        ibus.iresp_data_ok = 1'b1;
        ibus.iresp_data    = 32'h0000_0013;
        repeat (4) tick();
        ibus.iresp_data = 32'h1234_5678;
        stall_F         = 1'b1;
        #1;
        total++;
        if (dataF !== {32'h1234_5678, 64'h8000_0010, 1'b0}) begin
            bad++; $display("FAIL stall_capture got %h want %h", dataF, {32'h1234_5678, 64'h8000_0010, 1'b0});
        end
        tick();
        // A stray data_ok while holding (no request out) must be ignored.
        for (int c = 1; c < 5; c++) begin
            ibus.iresp_data_ok = (c == 2);
            ibus.iresp_data    = 32'hDEAD_BEEF;
            stall_F            = (c < 4);
            #1;
            total++;
            if (ibus.ireq_valid !== 1'b0) begin
                bad++; $display("FAIL hold_valid[%0d] got %b want 0", c, ibus.ireq_valid);
            end
            total++;
            if (dataF !== {32'h1234_5678, 64'h8000_0010, 1'b0}) begin
                bad++; $display("FAIL hold_dataF[%0d] got %h want %h", c, dataF, {32'h1234_5678, 64'h8000_0010, 1'b0});
            end
            tick();
        end
        ibus.iresp_data_ok = 1'b0;
        #1;
        total++;
        if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'h8000_0014}) begin
            bad++; $display("FAIL stall_resume got %b/%h want 1/80000014", ibus.ireq_valid, ibus.ireq_addr);
        end
    endtask

    task automatic test_redirect_pending;
        do_reset();
        ibus.iresp_data_ok = 1'b1;
        ibus.iresp_data    = 32'h0000_0013;
        repeat (8) tick();
        ibus.iresp_data_ok = 1'b0;
        redirect_valid     = 1'b1;
        redirect_pc        = 64'h8000_0100;
        for (int c = 0; c < 3; c++) begin
            ibus.iresp_data_ok = (c == 2);
            ibus.iresp_data    = 32'h0000_0BAD;
            #1;
            total++;
            if ({ibus.ireq_valid, ibus.ireq_addr, dataF.is_bubble} !== {1'b1, 64'h8000_0020, 1'b1}) begin
                bad++; $display("FAIL redir_pend[%0d] got %b/%h/%b want 1/80000020/1", c, ibus.ireq_valid, ibus.ireq_addr, dataF.is_bubble);
            end
            tick();
            redirect_valid = 1'b0;
        end
        ibus.iresp_data_ok = 1'b1;
        ibus.iresp_data    = 32'h0010_0093;
        #1;
        total++;
        if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'h8000_0100}) begin
            bad++; $display("FAIL redir_target got %b/%h want 1/80000100", ibus.ireq_valid, ibus.ireq_addr);
        end
        total++;
        if (dataF !== {32'h0010_0093, 64'h8000_0100, 1'b0}) begin
            bad++; $display("FAIL redir_dataF got %h want %h", dataF, {32'h0010_0093, 64'h8000_0100, 1'b0});
        end
    endtask

    task automatic test_redirect_with_data;
        do_reset();
        ibus.iresp_data_ok = 1'b1;
        ibus.iresp_data    = 32'h0000_0013;
        stall_F            = 1'b1;
        redirect_valid     = 1'b1;
        redirect_pc        = 64'h8000_0200;
        #1;
        total++;
        if (dataF.is_bubble !== 1'b1) begin
            bad++; $display("FAIL rdd_bubble got %b want 1", dataF.is_bubble);
        end
        tick();
        redirect_valid     = 1'b0;
        stall_F            = 1'b0;
        ibus.iresp_data_ok = 1'b0;
        #1;
        total++;
        if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'h8000_0200}) begin
            bad++; $display("FAIL rdd_next got %b/%h want 1/80000200", ibus.ireq_valid, ibus.ireq_addr);
        end
    endtask

    task automatic test_hold_redirect;
        do_reset();
        ibus.iresp_data_ok = 1'b1;
        ibus.iresp_data    = 32'h0000_1111;
        stall_F            = 1'b1;
        tick();
        ibus.iresp_data_ok = 1'b0;
        redirect_valid     = 1'b1;
        redirect_pc        = 64'h8000_0300;
        #1;
        total++;
        if ({ibus.ireq_valid, dataF.is_bubble} !== {1'b0, 1'b1}) begin
            bad++; $display("FAIL hold_redir got %b/%b want 0/1", ibus.ireq_valid, dataF.is_bubble);
        end
        tick();
        redirect_valid = 1'b0;
        stall_F        = 1'b0;
        #1;
        total++;
        if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'h8000_0300}) begin
            bad++; $display("FAIL hold_redir_next got %b/%h want 1/80000300", ibus.ireq_valid, ibus.ireq_addr);
        end
    endtask

    task automatic test_flush_latest;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        tick();
        redirect_pc = 64'h8000_0180;
        tick();
        redirect_valid     = 1'b0;
        ibus.iresp_data_ok = 1'b1;
        #1;
        total++;
        if ({ibus.ireq_valid, ibus.ireq_addr, dataF.is_bubble} !== {1'b1, 64'h8000_0000, 1'b1}) begin
            bad++; $display("FAIL flush_hold got %b/%h/%b want 1/80000000/1", ibus.ireq_valid, ibus.ireq_addr, dataF.is_bubble);
        end
        tick();
        ibus.iresp_data_ok = 1'b0;
        redirect_valid     = 1'b1;
        redirect_pc        = 64'h8000_0400;
        #1;
        total++;
        if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'h8000_0180}) begin
            bad++; $display("FAIL flush_latest got %b/%h want 1/80000180", ibus.ireq_valid, ibus.ireq_addr);
        end
        tick();
        redirect_pc        = 64'h8000_0480;
        ibus.iresp_data_ok = 1'b1;
        #1;
        total++;
        if ({ibus.ireq_valid, ibus.ireq_addr, dataF.is_bubble} !== {1'b1, 64'h8000_0180, 1'b1}) begin
            bad++; $display("FAIL flush_same got %b/%h/%b want 1/80000180/1", ibus.ireq_valid, ibus.ireq_addr, dataF.is_bubble);
        end
        tick();
        redirect_valid     = 1'b0;
        ibus.iresp_data_ok = 1'b0;
        #1;
        total++;
        if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'h8000_0480}) begin
            bad++; $display("FAIL flush_same_next got %b/%h want 1/80000480", ibus.ireq_valid, ibus.ireq_addr);
        end
    endtask

    task automatic test_reset_mid_flush;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        tick();
        redirect_valid     = 1'b0;
        reset              = 1'b0;
        ibus.iresp_data_ok = 1'b1;
        #1;
        total++;
        if (ibus.ireq_valid !== 1'b0) begin
            bad++; $display("FAIL rmf_valid got %b want 0", ibus.ireq_valid);
        end
        total++;
        if (dataF !== {32'h0, 64'h8000_0000, 1'b1}) begin
            bad++; $display("FAIL rmf_dataF got %h want %h", dataF, {32'h0, 64'h8000_0000, 1'b1});
        end
        tick();
        reset              = 1'b1;
        ibus.iresp_data_ok = 1'b0;
        #1;
        total++;
        if ({ibus.ireq_valid, ibus.ireq_addr, dataF.is_bubble} !== {1'b1, 64'h8000_0000, 1'b1}) begin
            bad++; $display("FAIL rmf_restart got %b/%h/%b want 1/80000000/1", ibus.ireq_valid, ibus.ireq_addr, dataF.is_bubble);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        ibus.iresp_data_ok = 1'b1;
        ibus.iresp_data    = 32'h0000_0013;
        redirect_valid     = 1'b1;
        redirect_pc        = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++;
        if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) begin
            bad++; $display("FAIL wrap_align got %b/%h want 1/fffffffffffffffc", ibus.ireq_valid, ibus.ireq_addr);
        end
        total++;
        if (dataF !== {32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0}) begin
            bad++; $display("FAIL wrap_dataF got %h want %h", dataF, {32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0});
        end
        tick();
        total++;
        if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'h0}) begin
            bad++; $display("FAIL wrap_zero got %b/%h want 1/0", ibus.ireq_valid, ibus.ireq_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_latency();
        test_stall();
        test_redirect_pending();
        test_redirect_with_data();
        test_hold_redirect();
        test_flush_latest();
        test_reset_mid_flush();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
